// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter: buffered long-latency entry and
// register-file geometry.
package wb_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  // An entry produces a register write only if it survived squashing and targets a real register.
  function automatic logic entry_live(entry_t e);
    return e.valid && (e.rd != '0);
  endfunction
endpackage

// File: rtl/wb_arb_fifo.sv
// Circular buffer for long-latency results with squash-by-destination and a
// pending-destination mask for the hazard unit.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  entry_t                i_push_ent,
  input  logic                  i_pop,
  input  logic                  i_squash,
  input  logic [REG_ADDR_W-1:0] i_squash_rd,
  output entry_t                o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [NUM_REGS-1:0]   o_pend_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LP_DEPTH = (PW+1)'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic            w_push;
  logic            w_pop;
  logic [NUM_REGS-1:0] w_mask;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == LP_DEPTH);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_head];

  // Popped slots are invalidated so valid bits only ever mark occupied entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_squash && r_mem[i].valid && (r_mem[i].rd == i_squash_rd))
          r_mem[i].valid <= 1'b0;
      if (w_pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (w_push) begin
        r_mem[r_tail] <= i_push_ent;
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_mem[i].valid) w_mask[r_mem[i].rd] = 1'b1;
    w_mask[0] = 1'b0;
  end

  assign o_pend_mask = w_mask;
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB pipeline and a buffered
// long-latency unit. Optional starvation guard: WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pipe_valid,
  input  logic [REG_ADDR_W-1:0] i_pipe_rd,
  input  logic [XLEN-1:0]       i_pipe_data,
  output logic                  o_pipe_stall,
  input  logic                  i_llu_valid,
  input  logic [REG_ADDR_W-1:0] i_llu_rd,
  input  logic [XLEN-1:0]       i_llu_data,
  output logic                  o_llu_ready,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_rd,
  output logic [XLEN-1:0]       o_rf_wdata,
  output logic [NUM_REGS-1:0]   o_pend_mask
);
  entry_t w_head;
  entry_t w_push_ent;
  logic   w_empty, w_full;
  logic   w_pipe_req, w_head_live, w_head_dead;
  logic   w_force, w_grant_pipe, w_grant_buf, w_pop, w_push;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wdata;

  assign w_pipe_req  = i_pipe_valid && (i_pipe_rd != '0);
  assign w_head_live = !w_empty && entry_live(w_head);
  // Squashed or x0-bound heads leave without using the port, so they drain every cycle.
  assign w_head_dead = !w_empty && !entry_live(w_head);
  assign o_llu_ready = !w_full && !i_rst;
  assign w_push      = i_llu_valid && o_llu_ready;
  assign w_push_ent  = '{valid: 1'b1, rd: i_llu_rd, data: i_llu_data};

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_force;

  assign w_force = r_force && !w_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_empty || w_grant_buf)
      w_cnt_nxt = '0;
    else if (w_grant_pipe && (r_cnt != LP_MAX))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_force <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (r_force && (w_grant_buf || w_empty))
        r_force <= 1'b0;
      else if (w_cnt_nxt == LP_MAX)
        r_force <= 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_grant_pipe = 1'b0;
    w_grant_buf  = 1'b0;
    if (w_force)
      w_grant_buf = w_head_live;
    else if (w_pipe_req)
      w_grant_pipe = 1'b1;
    else
      w_grant_buf = w_head_live;
  end

  assign w_pop        = w_grant_buf || w_head_dead;
  assign o_pipe_stall = w_force && w_pipe_req;

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_ent  (w_push_ent),
    .i_pop       (w_pop),
    .i_squash    (w_grant_pipe),
    .i_squash_rd (i_pipe_rd),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_pend_mask (o_pend_mask)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant_pipe || w_grant_buf;
      if (w_grant_pipe) begin
        r_rd    <= i_pipe_rd;
        r_wdata <= i_pipe_data;
      end else if (w_grant_buf) begin
        r_rd    <= w_head.rd;
        r_wdata <= w_head.data;
      end
    end
  end

  assign o_rf_we    = r_we;
  assign o_rf_rd    = r_rd;
  assign o_rf_wdata = r_wdata;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: register-file writes are checked against a
// scoreboard of expected writes; status outputs are checked inline.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pipe_valid(pipe_valid), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
    .o_pipe_stall(pipe_stall),
    .i_llu_valid(llu_valid), .i_llu_rd(llu_rd), .i_llu_data(llu_data),
    .o_llu_ready(llu_ready),
    .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wdata(rf_wdata),
    .o_pend_mask(pend_mask)
  );

  // Scoreboard: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected: got rd=%0d data=%h, expected no write", rf_rd, rf_wdata);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        checks++;
        assert ({rf_rd, rf_wdata} === {e.rd, e.data}) else begin
          errors++;
          $error("FAIL wr_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                 rf_rd, rf_wdata, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    llu_valid = v; llu_rd = rd; llu_data = d;
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back('{rd: rd, data: d});
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    llu(1'b0, 5'd0, 32'h0);
    tick(); tick();
    chk("rst_ready", {31'b0, llu_ready}, 32'd0);
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_we", {31'b0, rf_we}, 32'd0);
    chk("idle_ready", {31'b0, llu_ready}, 32'd1);
    chk("idle_pend", pend_mask, 32'd0);
    chk("idle_stall", {31'b0, pipe_stall}, 32'd0);

    // Pipe-only write, one-cycle latency, single-cycle enable.
    pipe(1'b1, 5'd5, 32'hDEAD_BEEF); expw(5'd5, 32'hDEAD_BEEF);
    tick();
    chk("pipe_we_hi", {31'b0, rf_we}, 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk("pipe_we_lo", {31'b0, rf_we}, 32'd0);
    chk("pipe_rd_hold", {27'b0, rf_rd}, 32'd5);

    // Contention: pipe wins twice, then the buffered result.
    pipe(1'b1, 5'd7, 32'hA); expw(5'd7, 32'hA);
    llu(1'b1, 5'd3, 32'h11);
    tick();
    chk("cont_pend1", pend_mask, 32'h8);
    llu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd7, 32'hB); expw(5'd7, 32'hB);
    tick();
    chk("cont_pend2", pend_mask, 32'h8);
    pipe(1'b0, 5'd0, 32'h0); expw(5'd3, 32'h11);
    tick();
    chk("cont_pend_clr", pend_mask, 32'h0);
    tick();
    chk("cont_we_lo", {31'b0, rf_we}, 32'd0);

    // Full buffer with a saturated pipe.
    pipe(1'b1, 5'd10, 32'h20); expw(5'd10, 32'h20);
    llu(1'b1, 5'd11, 32'h101);
    tick();
    chk("full_ready1", {31'b0, llu_ready}, 32'd1);
    pipe(1'b1, 5'd10, 32'h21); expw(5'd10, 32'h21);
    llu(1'b1, 5'd12, 32'h102);
    tick();
    chk("full_ready0", {31'b0, llu_ready}, 32'd0);
    pipe(1'b1, 5'd10, 32'h22); expw(5'd10, 32'h22);
    llu(1'b1, 5'd13, 32'h103);
    tick();
    chk("full_ready0b", {31'b0, llu_ready}, 32'd0);
    chk("full_pend", pend_mask, 32'h1800);
    pipe(1'b0, 5'd0, 32'h0); expw(5'd11, 32'h101);
    tick();
    chk("full_ready_after_pop", {31'b0, llu_ready}, 32'd1);
    expw(5'd12, 32'h102);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    chk("full_pend13", pend_mask, 32'h2000);
    expw(5'd13, 32'h103);
    tick();
    chk("full_pend_clr", pend_mask, 32'h0);
    tick();

    // WAW squash: buffered rd=9 is overwritten by the pipe and never written.
    pipe(1'b1, 5'd8, 32'h30); expw(5'd8, 32'h30);
    llu(1'b1, 5'd9, 32'h1);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    chk("waw_pend", pend_mask, 32'h200);
    pipe(1'b1, 5'd9, 32'h2); expw(5'd9, 32'h2);
    tick();
    chk("waw_pend_clr", pend_mask, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    tick(); tick();
    chk("waw_no_write", {31'b0, rf_we}, 32'd0);

    // pipe_rd==0 consumes no grant; buffer writes the same cycle.
    pipe(1'b1, 5'd4, 32'h40); expw(5'd4, 32'h40);
    llu(1'b1, 5'd6, 32'h66);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd0, 32'h99); expw(5'd6, 32'h66);
    tick();
    chk("x0_pipe_rd", {27'b0, rf_rd}, 32'd6);
    pipe(1'b0, 5'd0, 32'h0);
    tick();

    // llu_rd==0 is accepted and dropped silently.
    llu(1'b1, 5'd0, 32'h77);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    chk("x0_llu_pend", pend_mask, 32'h0);
    tick(); tick();
    chk("x0_llu_ready", {31'b0, llu_ready}, 32'd1);

    // Starvation: pipe held valid while rd=14 waits.
    pipe(1'b1, 5'd15, 32'h55); expw(5'd15, 32'h55);
    llu(1'b1, 5'd14, 32'hE);
    for (int i = 1; i <= 4; i++) begin
      tick();
      llu(1'b0, 5'd0, 32'h0);
      chk("starve_nostall", {31'b0, pipe_stall}, 32'd0);
      chk("starve_pend", pend_mask, 32'h4000);
      expw(5'd15, 32'h55);
    end
    tick();
`ifdef WB_ARB_STARVE_GUARD_EN
    chk("starve_stall", {31'b0, pipe_stall}, 32'd1);
    expw(5'd14, 32'hE);
    tick();
    chk("starve_stall_clr", {31'b0, pipe_stall}, 32'd0);
    chk("starve_pend_clr", pend_mask, 32'h0);
    expw(5'd15, 32'h55);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
`else
    chk("starve_off_stall", {31'b0, pipe_stall}, 32'd0);
    chk("starve_off_pend", pend_mask, 32'h4000);
    expw(5'd15, 32'h55);
    tick();
    pipe(1'b0, 5'd0, 32'h0); expw(5'd14, 32'hE);
    tick();
`endif
    tick(); tick();
    chk("starve_pend_end", pend_mask, 32'h0);

    // Reset mid-operation discards the buffered entry.
    pipe(1'b1, 5'd16, 32'h60); expw(5'd16, 32'h60);
    llu(1'b1, 5'd17, 32'h70);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    llu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    chk("mrst_we", {31'b0, rf_we}, 32'd0);
    chk("mrst_rd", {27'b0, rf_rd}, 32'd0);
    chk("mrst_pend", pend_mask, 32'h0);
    chk("mrst_ready", {31'b0, llu_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_ready1", {31'b0, llu_ready}, 32'd1);
    tick(); tick();
    chk("mrst_no_write", {31'b0, rf_we}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline's write-back stream and a long-latency unit (MUL/DIV) that completes out of band. Long-latency results wait in a small buffer until the port is free. An optional starvation guard briefly freezes the pipeline so buffered results drain. The block sits between the WB pipeline register, the long-latency unit and the register file, and exports a pending-destination mask to the hazard unit.

## Interface
- DEPTH, 2, long-latency result buffer entries (power of 2, ≥2)
- STARVE_MAX, 4, consecutive cycles a non-empty buffer may lose the port before forcing a drain (≥1)

- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  reset; synchronous, active-high
- pipe_valid  in  1  pipeline write request (WB-stage RegWrite)
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- pipe_stall  out  1  freeze WB stage this cycle; pipeline must hold pipe_* stable
- llu_valid  in  1  long-latency result valid
- llu_rd  in  5  long-latency destination
- llu_data  in  32  long-latency result
- llu_ready  out  1  buffer can accept; transfer when llu_valid && llu_ready
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- pend_mask  out  32  bit i set while any valid buffer entry targets x[i]; bit 0 always 0

## Operation
- Buffer: circular FIFO, head/tail pointers plus count; push on llu handshake, pop on buffer grant or squash.
- llu_ready = !full; no push when full, even if a pop occurs that cycle. llu_ready is 0 while rst is high.
- Per-cycle grant, highest first:
  - force_drain set and buffer non-empty → buffer head.
  - pipe_valid && pipe_rd≠0 → pipe.
  - Buffer non-empty → buffer head.
  - Otherwise no write.
- pipe_rd==0: request is dropped, consumes no grant, and the buffer may be granted the same cycle.
- llu_rd==0: accepted into the buffer but popped without a write when it reaches the head.
- WAW squash: when the pipe is granted rd=R, every valid buffer entry with rd=R is invalidated. An invalid head is popped without a write, and the pop still frees the slot.
- pend_mask is computed combinationally from valid entries; squashed entries are excluded immediately in the following cycle.
- Simultaneous push and grant of a non-empty buffer: the head is written and the new entry is appended. The new entry is never written the same cycle.

## Timing
- Grant-to-port latency is 1 cycle: a decision in cycle N appears on rf_* after edge N+1.
- rf_we is high for exactly one cycle per write. rf_rd and rf_wdata hold their last values when rf_we is 0.
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, pipe_stall=0, llu_ready=0 (1 from the first cycle after rst), pend_mask=0, buffer empty, starve counter=0, force_drain=0.
- Reset mid-operation: buffered entries are discarded without writes.
- Buffer wrap-around is transparent; pointers are log2(DEPTH) bits and count is log2(DEPTH)+1 bits.

## Configuration
- WB_ARB_STARVE_GUARD_EN defined:
  - Starve counter increments each cycle the buffer is non-empty and the pipe is granted.
  - The counter clears on a buffer grant or when the buffer is empty.
  - When the counter reaches STARVE_MAX, force_drain is set at the next edge.
  - While force_drain=1: pipe_stall = pipe_valid && pipe_rd≠0, and the buffer head is granted.
  - force_drain clears after one buffer grant, and the counter resets.
- Undefined: the pipe has strict priority, pipe_stall is tied 0, and neither the counter nor force_drain exists.

## Structure
- Package wb_arb_pkg: entry typedef {valid, rd[4:0], data[31:0]}, REG_ADDR_W=5, XLEN=32.
- Sub-module wb_arb_fifo: storage, pointers, count, squash-by-rd, pend_mask generation. The top level holds grant, starvation logic and output registers.

## Test plan
- Reset then idle: after rst deasserts, rf_we=0, llu_ready=1, pend_mask=0.
- Pipe only: pipe_valid, rd=5, data=0xDEAD_BEEF in cycle N → rf_we=1, rf_rd=5, rf_wdata=0xDEAD_BEEF in cycle N+1 only.
- Contention: llu rd=3, data=0x11, while pipe writes rd=7 for 2 cycles → rd=7 written twice, then rd=3 with 0x11. pend_mask bit 3 is set until the grant.
- Full buffer: three back-to-back llu pushes with the pipe saturated → llu_ready=0 after two. The third is accepted on the first cycle after a pop.
- WAW squash: buffer holds rd=9, data=0x1, and the pipe writes rd=9, data=0x2 → rf receives only 0x2, and pend_mask bit 9 clears.
- Starvation (guard on, STARVE_MAX=4): buffer non-empty, pipe_valid held, rd≠0 → after 4 pipe grants, pipe_stall=1 for one cycle and the buffer head is written. Guard off: the buffer waits until pipe_valid drops.
